// File: rtl/fetch_stage.sv
// Instruction fetch front end: issues imem word reads, tracks the PC and feeds decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counter ports.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        iq_full,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] fetch_pc_curr,
   output logic [31:0] fetch_pc_next
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned MASK_W = 4;
   localparam logic [MASK_W-1:0] RMASK_WORD = MASK_W'(4'b1111);
   localparam logic [XLEN-1:0]   PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0]   ALIGN_MASK = ~XLEN'(3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_buf_q, inst_buf_d;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] redir_pc;
   logic            push;

   assign pc_inc   = pc_q + PC_STEP;
   assign redir_pc = redirect_pc & ALIGN_MASK;

   // State, PC and held-instruction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         inst_buf_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_buf_q <= inst_buf_d;
      end
   end

   // Next state and interface outputs; a redirect wins over any push or latch
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_buf_d    = inst_buf_q;
      imem_rmask    = '0;
      imem_addr     = '0;
      inst_valid    = 1'b0;
      inst          = '0;
      fetch_pc_curr = '0;
      fetch_pc_next = '0;
      push          = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_ISSUE;
         end

         S_ISSUE: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
            end else begin
               imem_rmask = RMASK_WORD;
               imem_addr  = pc_q;
               state_d    = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = imem_resp ? S_ISSUE : S_DISCARD;
            end else if (imem_resp) begin
               if (!iq_full) begin
                  inst_valid = 1'b1;
                  inst       = imem_rdata;
                  push       = 1'b1;
                  pc_d       = pc_inc;
                  state_d    = S_ISSUE;
               end else begin
                  inst_buf_d = imem_rdata;
                  state_d    = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_pc;
               state_d = S_ISSUE;
            end else begin
               inst_valid = 1'b1;
               inst       = inst_buf_q;
               if (!iq_full) begin
                  push    = 1'b1;
                  pc_d    = pc_inc;
                  state_d = S_ISSUE;
               end
            end
         end

         S_DISCARD: begin
            // The stale response still has to drain before a new request may issue
            if (redirect_valid) begin
               pc_d = redir_pc;
            end
            if (imem_resp) begin
               state_d = S_ISSUE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (inst_valid) begin
         fetch_pc_curr = pc_q;
         fetch_pc_next = pc_inc;
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating push and queue-full stall counters, untouched by redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (push && (perf_fetched != '1)) begin
            perf_fetched <= perf_fetched + XLEN'(1);
         end
         if ((state_q == S_HOLD) && iq_full && (perf_stall != '1)) begin
            perf_stall <= perf_stall + XLEN'(1);
         end
      end
   end
`endif

`ifndef SYNTHESIS
   resp_when_outstanding_a : assert property (
      @(posedge clk) disable iff (!rst_n)
      imem_resp |-> ((state_q == S_WAIT) || (state_q == S_DISCARD))
   );
`endif

endmodule
